// File: rtl/controller_pkg.sv
// Shared types and constants for the 16-bit processor control unit.
// Holds the FSM state encoding, the opcode values, the ALU function codes
// and a helper that maps an opcode to its execute state.
package controller_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned DADDR_W = 8;
    localparam int unsigned RADDR_W = 4;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        LOAD_A = 4'd3,
        LOAD_B = 4'd4,
        STORE  = 4'd5,
        ADD    = 4'd6,
        SUB    = 4'd7,
        NOOP   = 4'd8,
        HALT   = 4'd9,
        PAUSE  = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_NOOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_STORE = 4'd1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'd2;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd3;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd4;
    localparam logic [OP_W-1:0] OP_HALT  = 4'd5;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

    // Opcode to execute state; unassigned opcodes behave as NOOP.
    function automatic state_t decode_op(input logic [OP_W-1:0] op);
        case (op)
            OP_STORE: decode_op = STORE;
            OP_LOAD:  decode_op = LOAD_A;
            OP_ADD:   decode_op = ADD;
            OP_SUB:   decode_op = SUB;
            OP_HALT:  decode_op = HALT;
            default:  decode_op = NOOP;
        endcase
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous load of RESET_PC on clr, increment on up.
// Wraps naturally from 2^PC_W-1 to 0.
// Ports: clk, clr (load RESET_PC), up (increment), pc (current value).
module program_counter #(
    parameter int unsigned PC_W     = 7,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            up,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (clr) begin
            pc <= PC_W'(RESET_PC);
        end else if (up) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/controller_fsm.sv
// Control unit of the 16-bit processor: owns PC and IR, fetches from a
// synchronous instruction ROM, decodes IR[15:12] and sequences the
// multi-cycle FSM that drives the Datapath control inputs.
// Ports: clk, reset (sync, active-high), I_data (ROM word), PC_addr,
//   IR_out, D_addr, D_wr, RF_sel, RF_W_en, WriteAddr, rdAddrA, rdAddrB,
//   ALU_s0, state_out, halted; step only with CTRL_SINGLE_STEP_EN.
// Build option CTRL_SINGLE_STEP_EN: retiring states park in PAUSE until a
//   cycle with step=1.
module controller_fsm
    import controller_pkg::*;
#(
    parameter int unsigned PC_W     = 7,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [INSTR_W-1:0] I_data,
    output logic [PC_W-1:0]    PC_addr,
    output logic [INSTR_W-1:0] IR_out,
    output logic [DADDR_W-1:0] D_addr,
    output logic               D_wr,
    output logic               RF_sel,
    output logic               RF_W_en,
    output logic [RADDR_W-1:0] WriteAddr,
    output logic [RADDR_W-1:0] rdAddrA,
    output logic [RADDR_W-1:0] rdAddrB,
    output logic [ALU_W-1:0]   ALU_s0,
    output logic [STATE_W-1:0] state_out,
    output logic               halted
);

`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t RETIRE_NEXT = PAUSE;
`else
    localparam state_t RETIRE_NEXT = FETCH;
`endif

    state_t             state;
    logic [INSTR_W-1:0] ir;

    // PC is held at RESET_PC through INIT so the ROM sees a stable address
    // for a full cycle before the first FETCH.
    program_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk (clk),
        .clr (reset || (state == INIT)),
        .up  (!reset && (state == FETCH)),
        .pc  (PC_addr)
    );

    // State and instruction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            ir    <= '0;
        end else begin
            case (state)
                INIT:   state <= FETCH;
                FETCH: begin
                    ir    <= I_data;
                    state <= DECODE;
                end
                DECODE: state <= decode_op(ir[15:12]);
                LOAD_A: state <= LOAD_B;
                LOAD_B, STORE, ADD, SUB, NOOP: state <= RETIRE_NEXT;
                HALT:   state <= HALT;
`ifdef CTRL_SINGLE_STEP_EN
                PAUSE:  state <= step ? FETCH : PAUSE;
`endif
                default: state <= INIT;
            endcase
        end
    end

    // Moore decode of state + IR; reset masks every enable immediately.
    always_comb begin
        D_addr  = ir[7:0];
        D_wr    = 1'b0;
        RF_sel  = 1'b0;
        RF_W_en = 1'b0;
        ALU_s0  = ALU_PASS;
        halted  = 1'b0;
        case (state)
            LOAD_A: begin
                D_addr = ir[11:4];
                RF_sel = 1'b1;
            end
            LOAD_B: begin
                D_addr  = ir[11:4];
                RF_sel  = 1'b1;
                RF_W_en = 1'b1;
            end
            STORE:  D_wr = 1'b1;
            ADD: begin
                ALU_s0  = ALU_ADD;
                RF_W_en = 1'b1;
            end
            SUB: begin
                ALU_s0  = ALU_SUB;
                RF_W_en = 1'b1;
            end
            HALT:   halted = 1'b1;
            default: ;
        endcase
        if (reset) begin
            D_wr    = 1'b0;
            RF_sel  = 1'b0;
            RF_W_en = 1'b0;
            ALU_s0  = ALU_PASS;
            halted  = 1'b0;
        end
    end

    assign IR_out    = ir;
    assign WriteAddr = ir[3:0];
    assign rdAddrA   = ir[11:8];
    assign rdAddrB   = ir[7:4];
    assign state_out = state;

endmodule

// File: tb/tb_controller_fsm.sv
// Self-checking bench for controller_fsm: a 7-bit-PC instance runs a small
// program through a table of expected per-cycle outputs, plus hand-written
// sequences for HALT hold, reset mid-LOAD, single-step and a 2-bit-PC
// instance that exercises PC wrap and NOOP decode of unused opcodes.
module tb_controller_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (PC_W = 7)
    logic        reset;
    logic [15:0] i_data;
    logic [6:0]  pc_addr;
    logic [15:0] ir_out;
    logic [7:0]  d_addr;
    logic        d_wr, rf_sel, rf_w_en, halted;
    logic [3:0]  write_addr, rd_addr_a, rd_addr_b, state_out;
    logic [2:0]  alu_s0;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step;
`endif

    logic [15:0] rom [128];
    always_ff @(posedge clk) i_data <= rom[pc_addr];

    controller_fsm #(.PC_W(7), .RESET_PC(0)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CTRL_SINGLE_STEP_EN
        .step      (step),
`endif
        .I_data    (i_data),
        .PC_addr   (pc_addr),
        .IR_out    (ir_out),
        .D_addr    (d_addr),
        .D_wr      (d_wr),
        .RF_sel    (rf_sel),
        .RF_W_en   (rf_w_en),
        .WriteAddr (write_addr),
        .rdAddrA   (rd_addr_a),
        .rdAddrB   (rd_addr_b),
        .ALU_s0    (alu_s0),
        .state_out (state_out),
        .halted    (halted)
    );

    // Second instance (PC_W = 2) for wrap checks
    logic        reset2;
    logic [15:0] i_data2;
    logic [1:0]  pc_addr2;
    logic [15:0] ir_out2;
    logic [7:0]  d_addr2;
    logic        d_wr2, rf_sel2, rf_w_en2, halted2;
    logic [3:0]  write_addr2, rd_addr_a2, rd_addr_b2, state_out2;
    logic [2:0]  alu_s02;

    logic [15:0] rom2 [4];
    always_ff @(posedge clk) i_data2 <= rom2[pc_addr2];

    controller_fsm #(.PC_W(2), .RESET_PC(0)) dut2 (
        .clk       (clk),
        .reset     (reset2),
`ifdef CTRL_SINGLE_STEP_EN
        .step      (1'b1),
`endif
        .I_data    (i_data2),
        .PC_addr   (pc_addr2),
        .IR_out    (ir_out2),
        .D_addr    (d_addr2),
        .D_wr      (d_wr2),
        .RF_sel    (rf_sel2),
        .RF_W_en   (rf_w_en2),
        .WriteAddr (write_addr2),
        .rdAddrA   (rd_addr_a2),
        .rdAddrB   (rd_addr_b2),
        .ALU_s0    (alu_s02),
        .state_out (state_out2),
        .halted    (halted2)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  st;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [7:0]  da;
        logic        dwr;
        logic        rfsel;
        logic        rfwe;
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        hlt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] st, input logic [6:0] pc,
                                input logic [15:0] ir, input logic [7:0] da, input logic dwr,
                                input logic rfsel, input logic rfwe, input logic [3:0] wa,
                                input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu,
                                input logic hlt);
        vec_t v;
        v.rst = r; v.st = st; v.pc = pc; v.ir = ir; v.da = da; v.dwr = dwr;
        v.rfsel = rfsel; v.rfwe = rfwe; v.wa = wa; v.ra = ra; v.rb = rb;
        v.alu = alu; v.hlt = hlt;
        return v;
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t v);
        return 64'({v.st, v.pc, v.ir, v.da, v.dwr, v.rfsel, v.rfwe, v.wa, v.ra, v.rb, v.alu, v.hlt});
    endfunction

    function automatic logic [63:0] pack_act();
        return 64'({state_out, pc_addr, ir_out, d_addr, d_wr, rf_sel, rf_w_en,
                    write_addr, rd_addr_a, rd_addr_b, alu_s0, halted});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [17];

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 16'hF000;
        rom[0] = 16'h3123;
        rom[1] = 16'h21BA;
        rom[2] = 16'h1A6A;
        rom[3] = 16'h4021;
        rom[4] = 16'h5000;
        rom2[0] = 16'hF000;
        rom2[1] = 16'h0000;
        rom2[2] = 16'h7123;
        rom2[3] = 16'hF000;

        //            rst st   pc    ir        da     dwr   sel   we    wa    ra    rb    alu   hlt
        vecs[0]  = mk(1, 4'd0, 7'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
        vecs[1]  = mk(0, 4'd1, 7'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
        vecs[2]  = mk(0, 4'd2, 7'd1, 16'h3123, 8'h23, 1'b0, 1'b0, 1'b0, 4'h3, 4'h1, 4'h2, 3'd0, 1'b0);
        vecs[3]  = mk(0, 4'd6, 7'd1, 16'h3123, 8'h23, 1'b0, 1'b0, 1'b1, 4'h3, 4'h1, 4'h2, 3'd1, 1'b0);
        vecs[4]  = mk(0, 4'd1, 7'd1, 16'h3123, 8'h23, 1'b0, 1'b0, 1'b0, 4'h3, 4'h1, 4'h2, 3'd0, 1'b0);
        vecs[5]  = mk(0, 4'd2, 7'd2, 16'h21BA, 8'hBA, 1'b0, 1'b0, 1'b0, 4'hA, 4'h1, 4'hB, 3'd0, 1'b0);
        vecs[6]  = mk(0, 4'd3, 7'd2, 16'h21BA, 8'h1B, 1'b0, 1'b1, 1'b0, 4'hA, 4'h1, 4'hB, 3'd0, 1'b0);
        vecs[7]  = mk(0, 4'd4, 7'd2, 16'h21BA, 8'h1B, 1'b0, 1'b1, 1'b1, 4'hA, 4'h1, 4'hB, 3'd0, 1'b0);
        vecs[8]  = mk(0, 4'd1, 7'd2, 16'h21BA, 8'hBA, 1'b0, 1'b0, 1'b0, 4'hA, 4'h1, 4'hB, 3'd0, 1'b0);
        vecs[9]  = mk(0, 4'd2, 7'd3, 16'h1A6A, 8'h6A, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 4'h6, 3'd0, 1'b0);
        vecs[10] = mk(0, 4'd5, 7'd3, 16'h1A6A, 8'h6A, 1'b1, 1'b0, 1'b0, 4'hA, 4'hA, 4'h6, 3'd0, 1'b0);
        vecs[11] = mk(0, 4'd1, 7'd3, 16'h1A6A, 8'h6A, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 4'h6, 3'd0, 1'b0);
        vecs[12] = mk(0, 4'd2, 7'd4, 16'h4021, 8'h21, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h2, 3'd0, 1'b0);
        vecs[13] = mk(0, 4'd7, 7'd4, 16'h4021, 8'h21, 1'b0, 1'b0, 1'b1, 4'h1, 4'h0, 4'h2, 3'd2, 1'b0);
        vecs[14] = mk(0, 4'd1, 7'd4, 16'h4021, 8'h21, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h2, 3'd0, 1'b0);
        vecs[15] = mk(0, 4'd2, 7'd5, 16'h5000, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b0);
        vecs[16] = mk(0, 4'd9, 7'd5, 16'h5000, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 3'd0, 1'b1);

        reset  = 1'b1;
        reset2 = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
        step   = 1'b0;
`endif
        tick();
        tick();

`ifndef CTRL_SINGLE_STEP_EN
        // Program trace ADD, LOAD, STORE, SUB, HALT
        for (int i = 0; i < 17; i++) begin
            reset = vecs[i].rst;
            tick();
            check($sformatf("vec%0d", i), pack_act(), pack_exp(vecs[i]));
        end

        // HALT holds PC and state
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("halt_hold%0d", i), 64'({state_out, pc_addr, halted}),
                  64'({4'd9, 7'd5, 1'b1}));
        end
`endif

        // Reset asserted during LOAD_B
        reset = 1'b1;
        tick();
        check("reset_init", 64'({state_out, pc_addr}), 64'({4'd0, 7'd0}));
        reset = 1'b0;
        for (int c = 0; c < 30 && state_out != 4'd4; c++) tick();
        check("reach_load_b", 64'(state_out), 64'(4'd4));
        check("load_b_we", 64'(rf_w_en), 64'(1'b1));
        reset = 1'b1;
        #1;
        check("reset_masks_enables", 64'({rf_w_en, rf_sel, d_wr, alu_s0}), 64'(0));
        tick();
        check("reset_mid_load", 64'({state_out, pc_addr, rf_w_en}), 64'({4'd0, 7'd0, 1'b0}));
        reset = 1'b0;

`ifdef CTRL_SINGLE_STEP_EN
        // ADD retires into PAUSE; no FETCH until step
        for (int i = 0; i < 4; i++) tick();
        check("pause_entry", 64'({state_out, pc_addr, rf_w_en}), 64'({4'd10, 7'd1, 1'b0}));
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("pause_hold%0d", i), 64'({state_out, pc_addr}), 64'({4'd10, 7'd1}));
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_fetch", 64'({state_out, pc_addr}), 64'({4'd1, 7'd1}));
        tick();
        check("step_decode", 64'({state_out, pc_addr, ir_out}), 64'({4'd2, 7'd2, 16'h21BA}));
`endif

        // 2-bit PC: four NOOP-class instructions and the wrap 3 -> 0
        reset2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 12 && state_out2 != 4'd2; c++) tick();
            check($sformatf("w_decode%0d", i), 64'({state_out2, pc_addr2, ir_out2}),
                  64'({4'd2, 2'((i + 1) % 4), rom2[i % 4]}));
            tick();
            check($sformatf("w_noop%0d", i), 64'({state_out2, rf_w_en2, d_wr2}),
                  64'({4'd8, 1'b0, 1'b0}));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
